// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, frame-state encoding and game key scan codes
// used by the keyboard receiver and the downstream game_state FSM.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BREAK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_RIGHT = 8'h74;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, 11-bit frame
// FSM with odd-parity check and an inactivity timeout inside a frame.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic [7:0]   byte_data,
  output logic         byte_valid,
  output logic         frame_err,
  output frame_state_t state_dbg
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]   r_clk_sync;
  logic [1:0]   r_data_sync;
  logic         r_clk_prev;
  frame_state_t r_state;
  frame_state_t w_next;
  logic [7:0]   r_shift;
  logic [2:0]   r_bit_cnt;
  logic         r_parity;
  logic [CW-1:0] r_to_cnt;

  logic w_fall;
  logic w_bit;
  logic w_timeout;
  logic w_frame_ok;

  // Sync flops reset to 1 (idle bus) so reset release cannot fake an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], ps2_clk};
      r_data_sync <= {r_data_sync[0], ps2_data};
      r_clk_prev  <= r_clk_sync[1];
    end
  end

  assign w_fall     = r_clk_prev & ~r_clk_sync[1];
  assign w_bit      = r_data_sync[1];
  assign w_timeout  = (r_state != IDLE) && !w_fall &&
                      (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_frame_ok = w_bit && (^{r_shift, r_parity});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_timeout) begin
      w_next = IDLE;
    end else if (w_fall) begin
      case (r_state)
        IDLE:    if (!w_bit) w_next = DATA;
        DATA:    if (r_bit_cnt == 3'd7) w_next = PARITY;
        PARITY:  w_next = STOP;
        STOP:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    byte_data  = r_shift;
    state_dbg  = r_state;
    byte_valid = w_fall && (r_state == STOP) && w_frame_ok;
    frame_err  = w_timeout ||
                 (w_fall && (r_state == IDLE) && w_bit) ||
                 (w_fall && (r_state == STOP) && !w_frame_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift   <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_parity  <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      if (w_fall || r_state == IDLE) r_to_cnt <= '0;
      else                           r_to_cnt <= r_to_cnt + 1'b1;
      if (w_fall) begin
        case (r_state)
          IDLE:   r_bit_cnt <= 3'd0;
          DATA: begin
            r_shift   <= {w_bit, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          PARITY: r_parity <= w_bit;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard front end: frame receiver plus E0/F0 prefix decoder that
// turns scan-code sequences into single make/break events.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_valid,
  output logic       key_release,
  output logic       frame_err
);

  logic [7:0]   w_byte;
  logic         w_byte_valid;
  logic         w_frame_err;
  frame_state_t w_state;

  logic       r_ext;
  logic       r_brk;
  logic [7:0] r_key_code;
  logic       r_key_ext;
  logic       r_key_valid;
  logic       r_key_release;
  logic       r_frame_err;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (PS2Clk),
    .ps2_data   (PS2Data),
    .byte_data  (w_byte),
    .byte_valid (w_byte_valid),
    .frame_err  (w_frame_err),
    .state_dbg  (w_state)
  );

  // A frame error discards any half-received prefix sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ext         <= 1'b0;
      r_brk         <= 1'b0;
      r_key_code    <= 8'h00;
      r_key_ext     <= 1'b0;
      r_key_valid   <= 1'b0;
      r_key_release <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_key_valid   <= 1'b0;
      r_key_release <= 1'b0;
      r_frame_err   <= w_frame_err;
      if (w_frame_err) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (w_byte_valid) begin
        if (w_byte == PS2_EXT) begin
          r_ext <= 1'b1;
        end else if (w_byte == PS2_BREAK) begin
          r_brk <= 1'b1;
        end else begin
          r_key_code    <= w_byte;
          r_key_ext     <= r_ext;
          r_key_release <= r_brk;
          r_key_valid   <= ~r_brk;
          r_ext         <= 1'b0;
          r_brk         <= 1'b0;
        end
      end
    end
  end

  assign key_code     = r_key_code;
  assign key_extended = r_key_ext;
  assign key_valid    = r_key_valid;
  assign key_release  = r_key_release;
  assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: bit-banged PS/2 frames, event counters
// sampled on the falling clk edge, hand-computed expected results.
module tb_ps2_keyboard;
  import ps2_pkg::*;

  localparam int TO = 1000;

  logic       clk;
  logic       rst;
  logic       ps2_clk_pin;
  logic       ps2_data_pin;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_valid;
  logic       key_release;
  logic       frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_rel    = 0;
  int n_err    = 0;
  int b_valid, b_rel, b_err;

  ps2_keyboard #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .PS2Clk       (ps2_clk_pin),
    .PS2Data      (ps2_data_pin),
    .key_code     (key_code),
    .key_extended (key_extended),
    .key_valid    (key_valid),
    .key_release  (key_release),
    .frame_err    (frame_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // event monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid)   n_valid++;
      if (key_release) n_rel++;
      if (frame_err)   n_err++;
      if (key_valid || key_release || frame_err)
        check("strobe_onehot", 32'(int'(key_valid) + int'(key_release) + int'(frame_err)), 32'd1);
    end
  end

  // driver tasks
  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data_pin = b;
    repeat (8) @(negedge clk);
    ps2_clk_pin = 1'b0;
    repeat (8) @(negedge clk);
    ps2_clk_pin = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(~bad_stop);
    ps2_data_pin = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic snap;
    b_valid = n_valid;
    b_rel   = n_rel;
    b_err   = n_err;
  endtask

  task automatic expect_ev(input string tag, input int v, input int r, input int e);
    check({tag, "_valid"},   32'(n_valid - b_valid), 32'(v));
    check({tag, "_release"}, 32'(n_rel - b_rel),     32'(r));
    check({tag, "_err"},     32'(n_err - b_err),     32'(e));
  endtask

  initial begin
    int n;
    rst = 1'b1;
    ps2_clk_pin = 1'b1;
    ps2_data_pin = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    check("rst_key_code", 32'(key_code), 32'h00);
    check("rst_key_ext", 32'(key_extended), 32'd0);
    check("rst_strobes", 32'({key_valid, key_release, frame_err}), 32'd0);
    check("rst_state", 32'(dut.u_frame_rx.state_dbg), 32'(IDLE));

    // plain make
    snap;
    send_frame(KEY_W, 1'b0, 1'b0);
    expect_ev("make_1d", 1, 0, 0);
    check("make_1d_code", 32'(key_code), 32'h1D);
    check("make_1d_ext", 32'(key_extended), 32'd0);

    // break F0 1D
    snap;
    send_frame(PS2_BREAK, 1'b0, 1'b0);
    expect_ev("brk_prefix", 0, 0, 0);
    send_frame(KEY_W, 1'b0, 1'b0);
    expect_ev("brk_1d", 0, 1, 0);
    check("brk_1d_code", 32'(key_code), 32'h1D);

    // extended make and break
    snap;
    send_frame(PS2_EXT, 1'b0, 1'b0);
    send_frame(KEY_UP, 1'b0, 1'b0);
    expect_ev("ext_make", 1, 0, 0);
    check("ext_make_code", 32'(key_code), 32'h75);
    check("ext_make_ext", 32'(key_extended), 32'd1);
    snap;
    send_frame(PS2_EXT, 1'b0, 1'b0);
    send_frame(PS2_BREAK, 1'b0, 1'b0);
    expect_ev("ext_prefixes", 0, 0, 0);
    send_frame(KEY_UP, 1'b0, 1'b0);
    expect_ev("ext_brk", 0, 1, 0);
    check("ext_brk_code", 32'(key_code), 32'h75);
    check("ext_brk_ext", 32'(key_extended), 32'd1);

    // parity error then good frame
    snap;
    send_frame(KEY_D, 1'b1, 1'b0);
    expect_ev("par_err", 0, 0, 1);
    check("par_err_code", 32'(key_code), 32'h75);
    snap;
    send_frame(KEY_A, 1'b0, 1'b0);
    expect_ev("after_par", 1, 0, 0);
    check("after_par_code", 32'(key_code), 32'h1C);
    check("after_par_ext", 32'(key_extended), 32'd0);

    // stop bit error
    snap;
    send_frame(KEY_S, 1'b0, 1'b1);
    expect_ev("stop_err", 0, 0, 1);
    check("stop_err_code", 32'(key_code), 32'h1C);

    // bad start bit in IDLE
    snap;
    ps2_bit(1'b1);
    repeat (8) @(negedge clk);
    expect_ev("start_err", 0, 0, 1);

    // timeout: start + 4 data bits, last fall timed by hand
    snap;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    @(negedge clk);
    ps2_data_pin = 1'b1;
    repeat (8) @(negedge clk);
    ps2_clk_pin = 1'b0;
    n = 0;
    while (n < 2 * TO) begin
      @(negedge clk);
      n++;
      if (n == 10) ps2_clk_pin = 1'b1;
      if (frame_err) break;
    end
    // 3 cycles of sync + edge, then TO cycles of counting
    check("timeout_latency", 32'(n), 32'(TO + 3));
    repeat (4) @(negedge clk);
    check("timeout_state", 32'(dut.u_frame_rx.state_dbg), 32'(IDLE));
    expect_ev("timeout", 0, 0, 1);
    snap;
    send_frame(KEY_SPACE, 1'b0, 1'b0);
    expect_ev("after_to", 1, 0, 0);
    check("after_to_code", 32'(key_code), 32'h29);

    // error discards pending E0
    snap;
    send_frame(PS2_EXT, 1'b0, 1'b0);
    send_frame(KEY_DOWN, 1'b1, 1'b0);
    send_frame(KEY_LEFT, 1'b0, 1'b0);
    expect_ev("ext_drop", 1, 0, 1);
    check("ext_drop_code", 32'(key_code), 32'h6B);
    check("ext_drop_ext", 32'(key_extended), 32'd0);

    // reset mid-frame
    snap;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge clk);
    ps2_clk_pin = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_code", 32'(key_code), 32'h00);
    check("midrst_strobes", 32'({key_extended, key_valid, key_release, frame_err}), 32'd0);
    check("midrst_state", 32'(dut.u_frame_rx.state_dbg), 32'(IDLE));
    ps2_clk_pin = 1'b1;
    ps2_data_pin = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    expect_ev("midrst", 0, 0, 0);
    check("midrst_code_hold", 32'(key_code), 32'h00);
    snap;
    send_frame(KEY_RIGHT, 1'b0, 1'b0);
    expect_ev("post_rst", 1, 0, 0);
    check("post_rst_code", 32'(key_code), 32'h74);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard.md
# ps2_keyboard

Receives scan codes from a PS/2 keyboard on the raw `PS2Clk`/`PS2Data` pins and delivers decoded key events to the game-state FSM. It sits directly upstream of `game_state`. It supplies the `key_code` byte plus one-cycle event strobes, and resolves the 0xE0 (extended) and 0xF0 (break) prefixes so that downstream logic sees one event per key press or release.

## Interface
- `TIMEOUT_CYCLES`, default 200000: number of `clk` cycles with no PS2Clk falling edge inside a frame before the frame is aborted (2 ms at 100 MHz).
- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  reset; asynchronous and active-high.
- `PS2Clk`  in  1  raw PS/2 clock pin, asynchronous to `clk`.
- `PS2Data`  in  1  raw PS/2 data pin, asynchronous to `clk`.
- `key_code`  out  8  scan byte of the last make or break event; holds its value between events.
- `key_extended`  out  1  high if that event was preceded by 0xE0; updated together with `key_code`.
- `key_valid`  out  1  one-cycle pulse: make (press) event.
- `key_release`  out  1  one-cycle pulse: break (release) event.
- `frame_err`  out  1  one-cycle pulse: bad start, parity or stop bit, or timeout.

## Operation
- Synchronisation: `PS2Clk` and `PS2Data` each pass through a 2-flop synchroniser. A falling edge is detected when the synced clock was 1 in the previous cycle and is 0 in the current cycle. `PS2Data` is sampled on that detected edge.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge with data = 0 (start bit), go to DATA. On an edge with data = 1, pulse `frame_err` and stay in IDLE.
  - DATA: shift in 8 bits LSB first; a 3-bit counter selects the bit. After bit 7, go to PARITY.
  - PARITY: latch the bit. The frame is good only if the data byte plus the parity bit contain an odd number of ones. Go to STOP.
  - STOP: stop bit must be 1. If stop and parity are good, emit the byte to the decoder; otherwise pulse `frame_err`. Return to IDLE in both cases.
- Timeout: the counter clears on every detected edge and in IDLE. In any non-IDLE state, reaching `TIMEOUT_CYCLES-1` pulses `frame_err` and forces IDLE.
- Decoder, acting on each good byte:
  - 0xE0: set the `ext` flag.
  - 0xF0: set the `brk` flag.
  - Any other byte: load `key_code` with the byte and `key_extended` with `ext`. Pulse `key_release` if `brk` is set, else pulse `key_valid`. Then clear both flags.
- A `frame_err` also clears `ext` and `brk`, so a half-received prefixed sequence is discarded.
- At most one of `key_valid`, `key_release`, `frame_err` is high in any cycle.
- Reset values: FSM = IDLE; counters 0; flags 0; `key_code` = 0x00; `key_extended`, `key_valid`, `key_release`, `frame_err` = 0. Synchroniser flops reset to 1 (bus idle) so that reset release does not produce a spurious edge.
- Reset asserted mid-frame aborts the frame immediately; no event is produced.

## Timing
- Edge-detect latency is 3 `clk` cycles after the pin falls: 2 synchroniser cycles plus 1 edge cycle.
- `key_valid`, `key_release` or `frame_err` (for parity/stop errors) is registered. It is high in the cycle after the cycle in which the stop-bit edge is detected.
- `key_code` and `key_extended` change in the same cycle as the strobe and are stable from then until the next event.
- The design requires PS2Clk high and low phases of at least 4 `clk` cycles each. Real keyboards give ~30 µs phases, far above this.
- Timeout `frame_err` is raised exactly `TIMEOUT_CYCLES` cycles after the last edge.

## Structure
- Package `ps2_pkg` holds:
  - `PS2_EXT` = 8'hE0 and `PS2_BREAK` = 8'hF0.
  - The frame-state enum.
  - Game key constants shared with `game_state`: W 8'h1D, A 8'h1C, S 8'h1B, D 8'h23, SPACE 8'h29; extended arrows UP 8'h75, LEFT 8'h6B, DOWN 8'h72, RIGHT 8'h74.
- Sub-module `ps2_frame_rx` contains the synchronisers, edge detect, frame FSM, parity check and timeout. It outputs `byte_data`, `byte_valid` and `frame_err`.
- `ps2_keyboard` wraps `ps2_frame_rx` with the prefix decoder.

## Test plan
- Send byte 0x1D with good parity -> one `key_valid` pulse, `key_code` = 0x1D, `key_extended` = 0.
- Send sequence F0, 1D -> no strobe after F0; `key_release` after 1D, `key_code` = 0x1D.
- Send sequence E0, 75 then E0, F0, 75 -> `key_valid` then `key_release`, each with `key_code` = 0x75 and `key_extended` = 1.
- Send 0x23 with the parity bit inverted -> `frame_err` pulse, no `key_valid`, `key_code` unchanged. The next good 0x1C decodes normally.
- Stop PS2Clk after 4 data bits (`TIMEOUT_CYCLES` = 1000) -> `frame_err` 1000 cycles after the last edge, FSM in IDLE. The following full frame 0x29 decodes correctly.
- Send E0 then an errored frame then 0x6B -> `key_valid` with `key_extended` = 0. Separately, assert `rst` mid-frame -> all outputs 0 and no event produced.
